// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs
//   Shared core definitions used by the CDB arbiter and its consumers
//   (reservation stations, map table, ROB).
//   - NUM_FU / PREG_W / QDEPTH : bus geometry
//   - PHYS_REG                 : physical register tag
//   - CDB_PACKET               : one broadcast {valid, tag, fu_idx}
// -----------------------------------------------------------------------------
package sys_defs;

   localparam int NUM_FU   = 4;
   localparam int PREG_W   = 6;
   localparam int QDEPTH   = 2;
   localparam int FU_IDX_W = $clog2(NUM_FU);
   localparam int CNT_W    = $clog2(QDEPTH + 1);

   typedef logic [PREG_W-1:0]   PHYS_REG;
   typedef logic [FU_IDX_W-1:0] FU_IDX;

   typedef struct packed {
      logic    valid;
      PHYS_REG tag;
      FU_IDX   fu_idx;
   } CDB_PACKET;

endpackage

// File: rtl/cdb_fu_queue.sv
// -----------------------------------------------------------------------------
// cdb_fu_queue
//   Two-entry completion FIFO owned by one functional unit.
//   Ports:
//     clock, reset   : clock / async active-high reset
//     flush          : synchronous squash, empties the queue
//     push, push_tag : enqueue request and tag (ignored when full or flushing)
//     pop            : dequeue the head (ignored when empty or flushing)
//     head           : tag at the head of the queue
//     count          : number of valid entries
//     ready          : queue can accept a push this cycle
// -----------------------------------------------------------------------------
module cdb_fu_queue
   import sys_defs::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  PHYS_REG          push_tag,
   input  logic             pop,
   output PHYS_REG          head,
   output logic [CNT_W-1:0] count,
   output logic             ready
);

   PHYS_REG          mem [QDEPTH];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   // Ready comes from the registered count only, so a full queue does not
   // accept a new entry in the same cycle it pops one.
   assign ready   = (cnt < CNT_W'(QDEPTH));
   assign do_push = push && ready && !flush;
   assign do_pop  = pop && (cnt != '0) && !flush;
   assign head    = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else if (flush) begin
         cnt    <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read once count covers it.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_tag;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Common Data Bus broadcaster. Buffers completing destination tags per FU
//   and broadcasts one per cycle, chosen round-robin among non-empty queues.
//   Ports:
//     clock, reset : clock / async active-high reset
//     flush        : branch-mispredict squash (empties queues, kills bus)
//     fu_done      : per-FU completion strobe
//     fu_tag       : per-FU destination tag, slice i belongs to FU i
//     fu_ready     : per-FU queue can accept a completion
//     cdb_valid    : registered broadcast valid
//     cdb_tag      : registered broadcast tag
//     cdb_fu_idx   : FU that produced cdb_tag
// -----------------------------------------------------------------------------
module cdb_arbiter
   import sys_defs::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NUM_FU-1:0]        fu_done,
   input  logic [NUM_FU*PREG_W-1:0] fu_tag,
   output logic [NUM_FU-1:0]        fu_ready,
   output logic                     cdb_valid,
   output logic [PREG_W-1:0]        cdb_tag,
   output logic [FU_IDX_W-1:0]      cdb_fu_idx
);

   PHYS_REG          q_head  [NUM_FU];
   logic [CNT_W-1:0] q_count [NUM_FU];
   logic [NUM_FU-1:0] q_pop;

   FU_IDX     last_grant;
   logic      grant_valid;
   FU_IDX     grant_idx;
   CDB_PACKET cdb_q;

   for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
      cdb_fu_queue u_queue (
         .clock    (clock),
         .reset    (reset),
         .flush    (flush),
         .push     (fu_done[g]),
         .push_tag (fu_tag[g*PREG_W +: PREG_W]),
         .pop      (q_pop[g]),
         .head     (q_head[g]),
         .count    (q_count[g]),
         .ready    (fu_ready[g])
      );

      assign q_pop[g] = grant_valid && (grant_idx == FU_IDX'(g)) && !flush;

      // An FU completing into a full queue loses its tag.
      protocol_check : assert property (
         @(posedge clock) disable iff (reset) !(fu_done[g] && !fu_ready[g])
      );
   end

   // Round-robin search starting just after the previous winner.
   always_comb begin
      int cand;
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 1; k <= NUM_FU; k++) begin
         cand = (int'(last_grant) + k) % NUM_FU;
         if (!grant_valid && (q_count[cand] != '0)) begin
            grant_valid = 1'b1;
            grant_idx   = FU_IDX'(cand);
         end
      end
   end

   // Tag and index hold when idle; only valid drops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cdb_q      <= '0;
         last_grant <= FU_IDX'(NUM_FU - 1);
      end else if (flush) begin
         cdb_q.valid <= 1'b0;
      end else if (grant_valid) begin
         cdb_q.valid  <= 1'b1;
         cdb_q.tag    <= q_head[grant_idx];
         cdb_q.fu_idx <= grant_idx;
         last_grant   <= grant_idx;
      end else begin
         cdb_q.valid <= 1'b0;
      end
   end

   assign cdb_valid  = cdb_q.valid;
   assign cdb_tag    = cdb_q.tag;
   assign cdb_fu_idx = cdb_q.fu_idx;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter. Inputs change 1 time unit after each
//   rising edge; registered outputs are observed at the same point.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
   import sys_defs::*;

   logic                     clock;
   logic                     reset;
   logic                     flush;
   logic [NUM_FU-1:0]        fu_done;
   logic [NUM_FU*PREG_W-1:0] fu_tag;
   logic [NUM_FU-1:0]        fu_ready;
   logic                     cdb_valid;
   logic [PREG_W-1:0]        cdb_tag;
   logic [FU_IDX_W-1:0]      cdb_fu_idx;

   int checks = 0;
   int errors = 0;

   cdb_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .fu_done    (fu_done),
      .fu_tag     (fu_tag),
      .fu_ready   (fu_ready),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_fu_idx (cdb_fu_idx)
   );

   // clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // driver tasks
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_tag(input int i, input logic [PREG_W-1:0] t);
      fu_tag[i*PREG_W +: PREG_W] = t;
   endtask

   task automatic idle_inputs();
      fu_done = '0;
      flush   = 1'b0;
   endtask

   // Expect a broadcast (or no broadcast) at the current observation point.
   task automatic expect_bcast(input string name, input logic v,
                               input logic [PREG_W-1:0] t, input logic [FU_IDX_W-1:0] idx);
      checks++;
      if (cdb_valid !== v) begin
         errors++;
         $display("FAIL %s valid: got %b expected %b", name, cdb_valid, v);
      end
      if (v) begin
         checks++;
         if (cdb_tag !== t || cdb_fu_idx !== idx) begin
            errors++;
            $display("FAIL %s data: got tag %h idx %0d expected tag %h idx %0d",
                     name, cdb_tag, cdb_fu_idx, t, idx);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      fu_tag = '0;
      step();
      step();
      reset = 1'b0;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_fu_idx !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v %b tag %h idx %0d expected 0 0 0",
                  cdb_valid, cdb_tag, cdb_fu_idx);
      end
      checks++;
      if (fu_ready !== 4'b1111) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 1111", fu_ready);
      end
      step();
   endtask

   // Fresh from reset: FU0 has first priority.
   task automatic test_contention();
      fu_done = 4'b1111;
      for (int i = 0; i < NUM_FU; i++) set_tag(i, PREG_W'(i + 1));
      step();
      idle_inputs();
      expect_bcast("contention_n1", 1'b0, '0, '0);
      step(); expect_bcast("contention_0", 1'b1, 6'd1, 2'd0);
      step(); expect_bcast("contention_1", 1'b1, 6'd2, 2'd1);
      step(); expect_bcast("contention_2", 1'b1, 6'd3, 2'd2);
      step(); expect_bcast("contention_3", 1'b1, 6'd4, 2'd3);
      step(); expect_bcast("contention_idle", 1'b0, '0, '0);
   endtask

   task automatic test_single_latency();
      fu_done = 4'b0100;
      set_tag(2, 6'h15);
      step();
      idle_inputs();
      expect_bcast("latency_n1", 1'b0, '0, '0);
      step();
      expect_bcast("latency_n2", 1'b1, 6'h15, 2'd2);
      checks++;
      if (fu_ready !== 4'b1111) begin
         errors++;
         $display("FAIL latency_ready: got %b expected 1111", fu_ready);
      end
      step();
      expect_bcast("latency_n3", 1'b0, '0, '0);
   endtask

   task automatic test_fairness();
      fu_done = 4'b0010;
      set_tag(1, 6'h11);
      step();
      fu_done = 4'b1001;
      set_tag(0, 6'h20);
      set_tag(3, 6'h33);
      step();
      idle_inputs();
      expect_bcast("fair_fu1", 1'b1, 6'h11, 2'd1);
      step(); expect_bcast("fair_fu3_first", 1'b1, 6'h33, 2'd3);
      step(); expect_bcast("fair_fu0_second", 1'b1, 6'h20, 2'd0);
      step(); expect_bcast("fair_idle", 1'b0, '0, '0);
   endtask

   // Enters with FU0 as last winner, so the order from here is 1,2,3,0.
   task automatic test_backpressure();
      fu_done = 4'b1111;
      set_tag(0, 6'h0a); set_tag(1, 6'h0b); set_tag(2, 6'h0c); set_tag(3, 6'h0d);
      step();
      checks++;
      if (fu_ready !== 4'b1111) begin
         errors++;
         $display("FAIL bp_ready_one_entry: got %b expected 1111", fu_ready);
      end
      fu_done = 4'b1111;
      set_tag(0, 6'h1a); set_tag(1, 6'h1b); set_tag(2, 6'h1c); set_tag(3, 6'h1d);
      step();
      idle_inputs();
      expect_bcast("bp_b0", 1'b1, 6'h0b, 2'd1);
      checks++;
      if (fu_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_ready_full: got %b expected 0010", fu_ready);
      end
      step();
      expect_bcast("bp_c0", 1'b1, 6'h0c, 2'd2);
      checks++;
      if (fu_ready[3] !== 1'b0) begin
         errors++;
         $display("FAIL bp_ready3_held: got %b expected 0", fu_ready[3]);
      end
      step();
      expect_bcast("bp_d0", 1'b1, 6'h0d, 2'd3);
      checks++;
      if (fu_ready !== 4'b1110) begin
         errors++;
         $display("FAIL bp_ready3_after_pop: got %b expected 1110", fu_ready);
      end
      step(); expect_bcast("bp_a0", 1'b1, 6'h0a, 2'd0);
      step(); expect_bcast("bp_b1", 1'b1, 6'h1b, 2'd1);
      step(); expect_bcast("bp_c1", 1'b1, 6'h1c, 2'd2);
      step(); expect_bcast("bp_d1", 1'b1, 6'h1d, 2'd3);
      step(); expect_bcast("bp_a1", 1'b1, 6'h1a, 2'd0);
      step(); expect_bcast("bp_idle", 1'b0, '0, '0);
   endtask

   task automatic test_flush();
      fu_done = 4'b1110;
      set_tag(1, 6'h2a); set_tag(2, 6'h2b); set_tag(3, 6'h2c);
      step();
      expect_bcast("flush_pre", 1'b0, '0, '0);
      fu_done = 4'b0001;
      set_tag(0, 6'h3f);
      flush = 1'b1;
      step();
      idle_inputs();
      expect_bcast("flush_next", 1'b0, '0, '0);
      checks++;
      if (fu_ready !== 4'b1111) begin
         errors++;
         $display("FAIL flush_ready: got %b expected 1111", fu_ready);
      end
      for (int c = 0; c < 4; c++) begin
         step();
         expect_bcast("flush_quiet", 1'b0, '0, '0);
      end
   endtask

   // Leaves FU1 as last winner, so a surviving pointer would favour FU3 over FU0.
   task automatic test_reset_midop();
      fu_done = 4'b0110;
      set_tag(1, 6'h21); set_tag(2, 6'h22);
      step();
      idle_inputs();
      step();
      expect_bcast("midrst_pre", 1'b1, 6'h21, 2'd1);
      #3 reset = 1'b1;
      #1;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_fu_idx !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: got v %b tag %h idx %0d expected 0 0 0",
                  cdb_valid, cdb_tag, cdb_fu_idx);
      end
      checks++;
      if (fu_ready !== 4'b1111) begin
         errors++;
         $display("FAIL midrst_ready: got %b expected 1111", fu_ready);
      end
      #2 reset = 1'b0;
      step();
      expect_bcast("midrst_lost", 1'b0, '0, '0);
      fu_done = 4'b1001;
      set_tag(0, 6'h31); set_tag(3, 6'h30);
      step();
      idle_inputs();
      step(); expect_bcast("midrst_fu0_first", 1'b1, 6'h31, 2'd0);
      step(); expect_bcast("midrst_fu3_second", 1'b1, 6'h30, 2'd3);
      step(); expect_bcast("midrst_idle", 1'b0, '0, '0);
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_latency();
      test_fairness();
      test_backpressure();
      test_flush();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus (CDB) broadcaster for the R10K-style out-of-order core. Collects completing destination tags from the functional units, buffers them per FU, and grants one completion per cycle round-robin. Broadcasts the winning physical-register tag to the reservation stations (their CAM wakeup input), the map table and the ROB. This is the producing end of the RS tag-match interface.

## Interface
- NUM_FU, 4: number of functional units feeding the bus; at least 2.
- PREG_W, 6: physical register tag width (64 physical registers).
- QDEPTH, 2: per-FU completion queue depth; fixed at 2 for this revision.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous branch-mispredict squash; empties all queues.
- fu_done  in  NUM_FU  per-FU completion strobe, one cycle per result.
- fu_tag  in  NUM_FU*PREG_W  per-FU destination tag; slice i belongs to FU i.
- fu_ready  out  NUM_FU  queue i can accept; FU i must not assert fu_done[i] while low.
- cdb_valid  out  1  broadcast valid this cycle.
- cdb_tag  out  PREG_W  broadcast physical-register tag.
- cdb_fu_idx  out  $clog2(NUM_FU)  index of the FU that produced cdb_tag.

## Operation
- Each FU owns a 2-entry FIFO of tags.
- Enqueue: on posedge, when fu_done[i] && fu_ready[i] && !flush.
- fu_done[i] while fu_ready[i] is low is a protocol violation. The arbiter drops the tag and raises an assertion in simulation.
- fu_ready[i] = (count_i < 2). It is computed from registered state only. A full queue does not accept a new entry in the same cycle it pops one.
- Arbitration: combinational over non-empty queue heads. Round-robin pointer last_grant; search order last_grant+1 ... last_grant, modulo NUM_FU.
- Winner is popped on posedge. cdb_valid/cdb_tag/cdb_fu_idx are registered from the winner. last_grant updates to the winner.
- No queue non-empty: cdb_valid goes low next cycle; last_grant holds; cdb_tag/cdb_fu_idx hold their previous values (don't-care to consumers).
- Order within one FU is FIFO. Across FUs only round-robin fairness is guaranteed.
- flush: all counts become 0 and cdb_valid becomes 0 at the next posedge. The fu_done input that cycle is ignored; last_grant is kept.
- The arbiter does no tag-zero or duplicate filtering. Consumers match tags as broadcast.

## Timing
- Reset values:
  - cdb_valid=0, cdb_tag=0, cdb_fu_idx=0.
  - all queues empty, so fu_ready = all ones.
  - last_grant = NUM_FU-1, so FU0 has first priority.
- Latency: fu_done in cycle N → entry at head in N+1 → cdb_valid in N+2, when uncontended with an empty queue. That is 2 cycles.
- Throughput: one broadcast per cycle total.
- A single FU issuing back-to-back reaches its steady state only when uncontended: one tag per cycle, fu_ready never drops.
- Under contention, each FU waits at most NUM_FU-1 grants once at head.
- Reset asserted mid-operation: outputs and queues clear asynchronously. In-flight tags are lost, by design; the core is reset as a whole.
- Simultaneous flush and reset: reset dominates.
- Wrap-around: queue read/write pointers are 1-bit and toggle. last_grant wraps from NUM_FU-1 to 0.

## Structure
- Shared package (sys_defs): PHYS_REG typedef (logic [PREG_W-1:0]), NUM_FU constant, and the CDB_PACKET struct {valid, tag, fu_idx} reused by RS, map table and ROB.
- Sub-module cdb_fu_queue: a 2-entry FIFO with push, pop, flush, head, count and ready. Instantiated NUM_FU times via generate.
- Top level contains the round-robin arbiter and the output register. No other hierarchy.

## Test plan
- Reset check:
  - Stimulus: assert reset mid-cycle with queues holding tags.
  - Required response: cdb_valid=0 and fu_ready=4'b1111 immediately; last_grant=3, so FU0 wins the first arbitration.
- Single FU latency:
  - Stimulus: fu_done[2]=1, tag=6'h15 in cycle N.
  - Required response: cdb_valid=1, cdb_tag=6'h15, cdb_fu_idx=2 in cycle N+2 only.
- All-FU contention:
  - Stimulus: all four FUs assert done in one cycle with tags 1,2,3,4.
  - Required response: broadcasts 1,2,3,4 on consecutive cycles in FU order 0,1,2,3.
- Fairness after a grant:
  - Stimulus: after FU1 wins, FU0 and FU3 both pending.
  - Required response: FU3 is granted before FU0.
- Backpressure:
  - Stimulus: hold FU0–FU3 busy and fill FU3's queue with 2 tags.
  - Required response: fu_ready[3]=0 until FU3's first pop; tags are broadcast in enqueue order.
- Flush:
  - Stimulus: queue tags on 3 FUs, then assert flush for one cycle together with fu_done[0]=1.
  - Required response: cdb_valid=0 on the next cycle; no queued or same-cycle tag is ever broadcast; fu_ready returns to all ones.
